// File: rtl/asd_src_router.sv
// MCU-controlled audio source router: oversampled SPI command slave, sticky
// status flags driving INT, and a mute-guarded source switch for the DAC path.
module asd_src_router #(
   parameter int         NUM_SOURCES = 3,
   parameter int         SRC_W       = 2,
   parameter logic [7:0] MAGIC       = 8'had,
   parameter int         MUTE_CYCLES = 4096,
   parameter int         RESET_SRC   = 0
) (
   input  logic                   MCU_OSC,
   input  logic                   RST,
   input  logic                   SCLK,
   input  logic                   nSS,
   input  logic                   MOSI,
   output logic                   MISO,
   output logic                   INT,
   input  logic [NUM_SOURCES-1:0] SPDIF_IN,
   input  logic [NUM_SOURCES-1:0] SCKI,
   input  logic [NUM_SOURCES-1:0] LRCKI,
   input  logic [NUM_SOURCES-1:0] BCKI,
   input  logic [NUM_SOURCES-1:0] DIN,
   input  logic                   EMPH,
   input  logic                   ERROR,
   input  logic                   nOVFL,
   output logic                   SPDIF,
   output logic                   SCKO,
   output logic                   LRCKO,
   output logic                   BCKO,
   output logic                   DOUT,
   output logic                   MUTE,
   output logic [SRC_W-1:0]       SRC
);

   localparam int CNT_W = $clog2(MUTE_CYCLES + 1);
   // Idle levels for {SCLK,nSS,MOSI,EMPH,ERROR,nOVFL} so reset release makes no edges.
   localparam logic [5:0] SYNC_IDLE = 6'b010001;

   typedef enum logic {PH_CMD, PH_DATA} phase_t;
   typedef enum logic [1:0] {CMD_MAGIC, CMD_SET, CMD_GET, CMD_STAT} cmd_t;
   typedef enum logic [1:0] {S_IDLE, S_PRE, S_SWITCH, S_POST} state_t;

   logic [5:0] sync1_q, sync2_q, sync3_q;
   logic       sclk_rise, sclk_fall, nss_s, mosi_s;
   logic       emph_ev, err_ev, ovfl_ev;

   always_ff @(posedge MCU_OSC or posedge RST) begin
      if (RST) begin
         sync1_q <= SYNC_IDLE;
         sync2_q <= SYNC_IDLE;
         sync3_q <= SYNC_IDLE;
      end else begin
         sync1_q <= {SCLK, nSS, MOSI, EMPH, ERROR, nOVFL};
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign sclk_rise = sync2_q[5] & ~sync3_q[5];
   assign sclk_fall = ~sync2_q[5] & sync3_q[5];
   assign nss_s     = sync2_q[4];
   assign mosi_s    = sync2_q[3];
   assign emph_ev   = sync2_q[2] ^ sync3_q[2];
   assign err_ev    = sync2_q[1] & ~sync3_q[1];
   assign ovfl_ev   = ~sync2_q[0] & sync3_q[0];

   logic [2:0]       bit_cnt_q, bit_cnt_d;
   phase_t           phase_q, phase_d;
   cmd_t             cmd_q, cmd_d;
   logic [6:0]       rx_q, rx_d;
   logic [7:0]       tx_q, tx_d;
   logic             miso_q, miso_d;
   logic [SRC_W-1:0] pending_q, pending_d;
   logic [3:0]       flags_q, flags_d;   // {bad_cmd, ovfl, err, emph_chg}
   logic             int_q, int_d;
   logic [7:0]       rx_byte;
   logic             bad_ev, clr;

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      cmd_d     = cmd_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      pending_d = pending_q;
      bad_ev    = 1'b0;
      clr       = 1'b0;
      rx_byte   = {rx_q, mosi_s};
      if (nss_s) begin
         bit_cnt_d = '0;
         phase_d   = PH_CMD;
         rx_d      = '0;
         tx_d      = '0;
         miso_d    = 1'b0;
      end else if (sclk_rise) begin
         rx_d      = rx_byte[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            tx_d = '0;
            if (phase_q == PH_CMD) begin
               phase_d = PH_DATA;
               case (rx_byte)
                  8'h01: begin cmd_d = CMD_MAGIC; tx_d = MAGIC; end
                  8'h02: cmd_d = CMD_SET;
                  8'h03: begin cmd_d = CMD_GET; tx_d = 8'(pending_q); end
                  8'h04: begin cmd_d = CMD_STAT; tx_d = {4'b0, flags_q}; end
                  default: begin phase_d = PH_CMD; bad_ev = 1'b1; end
               endcase
            end else begin
               phase_d = PH_CMD;
               if (cmd_q == CMD_SET) begin
                  if (rx_byte < 8'(NUM_SOURCES)) pending_d = rx_byte[SRC_W-1:0];
                  else                          bad_ev    = 1'b1;
               end
               if (cmd_q == CMD_STAT) clr = 1'b1;
            end
         end
      end else if (sclk_fall) begin
         miso_d = tx_q[7];
         tx_d   = {tx_q[6:0], 1'b0};
      end
      // A flag event in the clear cycle survives the clear.
      flags_d = (flags_q & {4{~clr}}) | {bad_ev, ovfl_ev, err_ev, emph_ev};
      int_d   = |flags_d;
   end

   always_ff @(posedge MCU_OSC or posedge RST) begin
      if (RST) begin
         bit_cnt_q <= '0;
         phase_q   <= PH_CMD;
         cmd_q     <= CMD_MAGIC;
         rx_q      <= '0;
         tx_q      <= '0;
         miso_q    <= 1'b0;
         pending_q <= SRC_W'(RESET_SRC);
         flags_q   <= '0;
         int_q     <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         cmd_q     <= cmd_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         miso_q    <= miso_d;
         pending_q <= pending_d;
         flags_q   <= flags_d;
         int_q     <= int_d;
      end
   end

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mute_q;
   logic [SRC_W-1:0] src_q;

   // Mute sequence: PRE holds MUTE for MUTE_CYCLES, SWITCH commits, POST holds again.
   always_ff @(posedge MCU_OSC or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mute_q  <= 1'b0;
         src_q   <= SRC_W'(RESET_SRC);
      end else begin
         case (state_q)
            S_IDLE: if (pending_q != src_q) begin
               mute_q  <= 1'b1;
               cnt_q   <= CNT_W'(MUTE_CYCLES - 1);
               state_q <= S_PRE;
            end
            S_PRE: begin
               if (cnt_q == '0) state_q <= S_SWITCH;
               else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            S_SWITCH: begin
               src_q   <= pending_q;
               cnt_q   <= CNT_W'(MUTE_CYCLES - 1);
               state_q <= S_POST;
            end
            S_POST: begin
               if (cnt_q == '0) begin
                  mute_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign MISO  = miso_q;
   assign INT   = int_q;
   assign MUTE  = mute_q;
   assign SRC   = src_q;
   assign SPDIF = SPDIF_IN[src_q];
   assign SCKO  = SCKI[src_q];
   assign LRCKO = LRCKI[src_q];
   assign BCKO  = BCKI[src_q];
   assign DOUT  = DIN[src_q];

endmodule

// File: tb/tb_asd_src_router.sv
// Bench for asd_src_router: SPI frames from a bit-banged master, checked
// against a small model of pending/committed source and status flags.
`timescale 1ns/1ps
module tb_asd_src_router;
   localparam int M  = 8;
   localparam int ML = 200;

   logic clk = 0, rst = 0, sclk = 0, nss = 1, mosi = 0;
   logic emph = 0, err = 0, novfl = 1;
   logic [2:0] spdif_in = 0, scki = 0, lrcki = 0, bcki = 0, din = 0;
   logic miso, intr, spdif, scko, lrcko, bcko, dout, mute;
   logic [1:0] src;
   logic l_miso, l_intr, l_spdif, l_scko, l_lrcko, l_bcko, l_dout, l_mute;
   logic [1:0] l_src;

   always #5 clk = ~clk;

   asd_src_router #(.NUM_SOURCES(3), .SRC_W(2), .MAGIC(8'had), .MUTE_CYCLES(M), .RESET_SRC(0)) dut (
      .MCU_OSC(clk), .RST(rst), .SCLK(sclk), .nSS(nss), .MOSI(mosi), .MISO(miso), .INT(intr),
      .SPDIF_IN(spdif_in), .SCKI(scki), .LRCKI(lrcki), .BCKI(bcki), .DIN(din),
      .EMPH(emph), .ERROR(err), .nOVFL(novfl), .SPDIF(spdif), .SCKO(scko), .LRCKO(lrcko),
      .BCKO(bcko), .DOUT(dout), .MUTE(mute), .SRC(src));

   // Long-mute instance so writes can land inside PRE/POST windows.
   asd_src_router #(.NUM_SOURCES(3), .SRC_W(2), .MAGIC(8'had), .MUTE_CYCLES(ML), .RESET_SRC(0)) dut_l (
      .MCU_OSC(clk), .RST(rst), .SCLK(sclk), .nSS(nss), .MOSI(mosi), .MISO(l_miso), .INT(l_intr),
      .SPDIF_IN(spdif_in), .SCKI(scki), .LRCKI(lrcki), .BCKI(bcki), .DIN(din),
      .EMPH(emph), .ERROR(err), .nOVFL(novfl), .SPDIF(l_spdif), .SCKO(l_scko), .LRCKO(l_lrcko),
      .BCKO(l_bcko), .DOUT(l_dout), .MUTE(l_mute), .SRC(l_src));

   int n_vec = 0, n_err = 0, cycle = 0;
   logic [1:0] m_pend, m_src;
   logic       m_bad;
   logic [7:0] fr_tx [8];
   logic [7:0] fr_rx [8];

   typedef struct {int cyc; logic mute; logic [1:0] src; logic dout;} ev_t;
   ev_t ev_q[$], evl_q[$];
   logic p_mute, p_dout, pl_mute;
   logic [1:0] p_src, pl_src;

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      ev_t e;
      if (mute !== p_mute || src !== p_src || dout !== p_dout) begin
         e.cyc = cycle; e.mute = mute; e.src = src; e.dout = dout;
         ev_q.push_back(e);
         p_mute = mute; p_src = src; p_dout = dout;
      end
      if (l_mute !== pl_mute || l_src !== pl_src) begin
         e.cyc = cycle; e.mute = l_mute; e.src = l_src; e.dout = 1'b0;
         evl_q.push_back(e);
         pl_mute = l_mute; pl_src = l_src;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit err_last, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         sclk = 0; mosi = tx[i]; cyc(5);
         sclk = 1; rx[i] = miso;
         if (err_last && i == 0) err = 1;
         cyc(5);
      end
      sclk = 0;
   endtask

   task automatic spi_frame(input int n, input bit err_last);
      logic [7:0] r;
      nss = 0; cyc(5);
      for (int b = 0; b < n; b++) begin
         spi_bits(fr_tx[b], 8, err_last && (b == n - 1), r);
         fr_rx[b] = r;
      end
      cyc(5); nss = 1; cyc(10);
   endtask

   task automatic do_reset();
      rst = 1; nss = 1; sclk = 0; mosi = 0; err = 0; emph = 0; novfl = 1;
      cyc(3); rst = 0; cyc(5);
      m_pend = 0; m_src = 0; m_bad = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %0b want 0", miso); end
      n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL reset_int: got %0b want 0", intr); end
      n_vec++; if (mute !== 1'b0) begin n_err++; $display("FAIL reset_mute: got %0b want 0", mute); end
      n_vec++; if (src !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", src); end
   endtask

   task automatic test_magic();
      fr_tx[0] = 8'h01; fr_tx[1] = 8'h00;
      spi_frame(2, 0);
      n_vec++; if (fr_rx[0] !== 8'h00) begin n_err++; $display("FAIL magic_cmd_miso: got %0h want 00", fr_rx[0]); end
      n_vec++; if (fr_rx[1] !== 8'had) begin n_err++; $display("FAIL magic_resp: got %0h want ad", fr_rx[1]); end
      n_vec++; if (src !== 2'd0 || mute !== 1'b0 || intr !== 1'b0)
         begin n_err++; $display("FAIL magic_state: got src=%0d mute=%0b int=%0b want 0/0/0", src, mute, intr); end
   endtask

   task automatic test_switch();
      din = 3'b100;
      cyc(2); ev_q.delete();
      fr_tx[0] = 8'h02; fr_tx[1] = 8'h02;
      spi_frame(2, 0);
      cyc(30);
      m_pend = 2; m_src = 2;
      n_vec++;
      if (ev_q.size() != 3) begin
         n_err++; $display("FAIL switch_events: got %0d events want 3", ev_q.size());
      end else begin
         if (ev_q[0].mute !== 1'b1 || ev_q[0].src !== 2'd0 || ev_q[0].dout !== 1'b0)
            begin n_err++; $display("FAIL switch_pre: got mute=%0b src=%0d dout=%0b want 1/0/0", ev_q[0].mute, ev_q[0].src, ev_q[0].dout); end
         n_vec++; if (ev_q[1].cyc - ev_q[0].cyc != M + 1)
            begin n_err++; $display("FAIL switch_pre_len: got %0d want %0d", ev_q[1].cyc - ev_q[0].cyc, M + 1); end
         n_vec++; if (ev_q[1].mute !== 1'b1 || ev_q[1].src !== 2'd2 || ev_q[1].dout !== 1'b1)
            begin n_err++; $display("FAIL switch_commit: got mute=%0b src=%0d dout=%0b want 1/2/1", ev_q[1].mute, ev_q[1].src, ev_q[1].dout); end
         n_vec++; if (ev_q[2].cyc - ev_q[1].cyc != M)
            begin n_err++; $display("FAIL switch_post_len: got %0d want %0d", ev_q[2].cyc - ev_q[1].cyc, M); end
         n_vec++; if (ev_q[2].mute !== 1'b0 || ev_q[2].src !== 2'd2)
            begin n_err++; $display("FAIL switch_end: got mute=%0b src=%0d want 0/2", ev_q[2].mute, ev_q[2].src); end
      end
   endtask

   task automatic test_bad_src();
      fr_tx[0] = 8'h02; fr_tx[1] = 8'h05;
      spi_frame(2, 0);
      cyc(20);
      n_vec++; if (src !== m_src || mute !== 1'b0) begin n_err++; $display("FAIL badsrc_keep: got src=%0d mute=%0b want %0d/0", src, mute, m_src); end
      n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL badsrc_int: got %0b want 1", intr); end
      fr_tx[0] = 8'h04; fr_tx[1] = 8'h00;
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== 8'h08) begin n_err++; $display("FAIL badsrc_status: got %0h want 08", fr_rx[1]); end
      n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL badsrc_int_clr: got %0b want 0", intr); end
   endtask

   task automatic test_status();
      err = 1; cyc(6); err = 0; novfl = 0; cyc(6); novfl = 1; cyc(6);
      n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL status_int: got %0b want 1", intr); end
      fr_tx[0] = 8'h04; fr_tx[1] = 8'h00;
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== 8'h06) begin n_err++; $display("FAIL status_err_ovfl: got %0h want 06", fr_rx[1]); end
      // ERROR rises exactly on the clearing edge: err must survive.
      spi_frame(2, 1);
      n_vec++; if (fr_rx[1] !== 8'h00) begin n_err++; $display("FAIL status_cleared: got %0h want 00", fr_rx[1]); end
      err = 0; cyc(6);
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== 8'h02) begin n_err++; $display("FAIL status_clr_race: got %0h want 02", fr_rx[1]); end
      emph = 1; cyc(6); emph = 0; cyc(6);
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== 8'h01) begin n_err++; $display("FAIL status_emph: got %0h want 01", fr_rx[1]); end
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== 8'h00) begin n_err++; $display("FAIL status_empty: got %0h want 00", fr_rx[1]); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         int k = 0;
         logic [7:0] v;
         logic [7:0] exp_get;
         if ($urandom_range(0, 2) == 0) begin
            fr_tx[k] = 8'($urandom_range(5, 255)); k++; m_bad = 1;
         end
         v = 8'($urandom_range(0, 4));
         fr_tx[k] = 8'h02; fr_tx[k+1] = v; fr_tx[k+2] = 8'h03; fr_tx[k+3] = 8'h00;
         if (v < 3) m_pend = v[1:0]; else m_bad = 1;
         exp_get = {6'b0, m_pend};
         spi_frame(k + 4, 0);
         m_src = m_pend;
         cyc(30);
         n_vec++; if (fr_rx[k+3] !== exp_get) begin n_err++; $display("FAIL rand_get_src: got %0h want %0h (wrote %0h)", fr_rx[k+3], exp_get, v); end
         n_vec++; if (src !== m_src || mute !== 1'b0) begin n_err++; $display("FAIL rand_src: got src=%0d mute=%0b want %0d/0", src, mute, m_src); end
         spdif_in = 3'($urandom); scki = 3'($urandom); lrcki = 3'($urandom); bcki = 3'($urandom); din = 3'($urandom);
         cyc(1);
         n_vec++;
         if ({spdif, scko, lrcko, bcko, dout} !== {spdif_in[m_src], scki[m_src], lrcki[m_src], bcki[m_src], din[m_src]})
            begin n_err++; $display("FAIL rand_route: got %05b want %05b", {spdif, scko, lrcko, bcko, dout},
                  {spdif_in[m_src], scki[m_src], lrcki[m_src], bcki[m_src], din[m_src]}); end
      end
      fr_tx[0] = 8'h04; fr_tx[1] = 8'h00;
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== {4'b0, m_bad, 3'b0}) begin n_err++; $display("FAIL rand_status: got %0h want %0h", fr_rx[1], {4'b0, m_bad, 3'b0}); end
   endtask

   task automatic test_pre_post();
      logic [1:0] es [6];
      logic       em [6];
      int         i;
      es[0] = 0; es[1] = 1; es[2] = 1; es[3] = 1; es[4] = 2; es[5] = 2;
      em[0] = 1; em[1] = 1; em[2] = 0; em[3] = 1; em[4] = 1; em[5] = 0;
      do_reset();
      evl_q.delete();
      fr_tx[0] = 8'h02; fr_tx[1] = 8'h02; fr_tx[2] = 8'h02; fr_tx[3] = 8'h01; fr_tx[4] = 8'h02; fr_tx[5] = 8'h02;
      spi_frame(6, 0);
      for (i = 0; i < 1500 && !(evl_q.size() >= 6 && l_mute === 1'b0); i++) cyc(1);
      cyc(5);
      n_vec++;
      if (evl_q.size() != 6) begin
         n_err++; $display("FAIL prepost_events: got %0d events want 6", evl_q.size());
      end else begin
         for (int j = 0; j < 6; j++) begin
            n_vec++;
            if (evl_q[j].src !== es[j] || evl_q[j].mute !== em[j])
               begin n_err++; $display("FAIL prepost_seq%0d: got src=%0d mute=%0b want %0d/%0b", j, evl_q[j].src, evl_q[j].mute, es[j], em[j]); end
         end
      end
      n_vec++; if (l_src !== 2'd2) begin n_err++; $display("FAIL prepost_final: got %0d want 2", l_src); end
   endtask

   task automatic test_abort_and_rst();
      logic [7:0] r;
      int i;
      do_reset();
      nss = 0; cyc(5);
      spi_bits(8'h02, 8, 0, r);
      spi_bits(8'h02, 5, 0, r);
      cyc(5); nss = 1; cyc(40);
      n_vec++; if (src !== 2'd0 || mute !== 1'b0 || intr !== 1'b0)
         begin n_err++; $display("FAIL abort_state: got src=%0d mute=%0b int=%0b want 0/0/0", src, mute, intr); end
      fr_tx[0] = 8'h03; fr_tx[1] = 8'h00;
      spi_frame(2, 0);
      n_vec++; if (fr_rx[1] !== 8'h00) begin n_err++; $display("FAIL abort_pending: got %0h want 00", fr_rx[1]); end
      nss = 0; cyc(5);
      spi_bits(8'h02, 8, 0, r);
      spi_bits(8'h01, 8, 0, r);
      for (i = 0; i < 10 && mute !== 1'b1; i++) cyc(1);
      n_vec++; if (mute !== 1'b1) begin n_err++; $display("FAIL rst_pre_entry: got mute=%0b want 1", mute); end
      rst = 1; cyc(1);
      n_vec++; if (mute !== 1'b0 || src !== 2'd0) begin n_err++; $display("FAIL rst_pre: got mute=%0b src=%0d want 0/0", mute, src); end
      cyc(2); rst = 0; nss = 1; cyc(30);
      n_vec++; if (mute !== 1'b0 || src !== 2'd0) begin n_err++; $display("FAIL rst_idle: got mute=%0b src=%0d want 0/0", mute, src); end
   endtask

   initial begin
      test_reset();
      test_magic();
      test_switch();
      test_bad_src();
      test_status();
      test_random();
      test_pre_post();
      test_abort_and_rst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
